vme_master_wide64: RTL and testbench
====================================

Name: vme_master_wide64

Overview:
- Bus initiator for the single-strobe VME-style register interface that the team's generated register banks respond on (VMEAddr / VMERdMem / VMEWrMem / VMERdDone / VMEWrDone).
- Accepts one 64-bit read or write request per transaction from a local host port.
- Splits each request into two 32-bit accesses, high word first at the 8-byte-aligned base, then low word at base+4.
- Reassembles read data and returns a single response. Used in testbenches and in on-chip controllers that drive 64-bit registers such as r1-style blocks.

Parameters:
- ADDR_WIDTH, 3: width of the byte address; the bus address port carries bits [ADDR_WIDTH-1:2].
- TIMEOUT_CYCLES, 255: maximum wait cycles for a Done per word (used only with the optional feature); 8-bit counter minimum, sized with clog2.

Ports:
- Clk  in  1  single clock, all logic on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high only in IDLE; a transfer occurs on valid&ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address; bits [2:0] ignored (forced to 0).
- req_wdata  in  64  write data.
- resp_valid  out  1  one-cycle pulse when the transaction ends.
- resp_rdata  out  64  read data, valid with resp_valid.
- resp_err  out  1  timeout flag, valid with resp_valid.
- VMEAddr  out  ADDR_WIDTH-2  word address to the responder.
- VMEWrData  out  32  write data to the responder.
- VMERdData  in  32  read data from the responder.
- VMERdMem  out  1  one-cycle read strobe.
- VMEWrMem  out  1  one-cycle write strobe.
- VMERdDone  in  1  read acknowledge.
- VMEWrDone  in  1  write acknowledge.

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0 except req_ready=1. Captured data and counters cleared. Any in-flight strobe drops at once and no response is produced.
- States: IDLE, ISSUE_HI, WAIT_HI, ISSUE_LO, WAIT_LO, RESP.
- IDLE -> ISSUE_HI on valid&ready. Latch the command, base address (bits [2:0]=0) and wdata.
- ISSUE_HI (1 cycle):
  - Drive VMEAddr = base word address and VMEWrData = wdata[63:32].
  - Pulse exactly one of VMERdMem/VMEWrMem.
  - Go to WAIT_HI.
- WAIT_HI:
  - Hold VMEAddr/VMEWrData stable; strobes are low.
  - On the matching Done (RdDone for read, WrDone for write): capture VMERdData into rdata[63:32] on reads, then go to ISSUE_LO.
  - The non-matching Done is ignored.
- ISSUE_LO / WAIT_LO: same as the HI pair, with address base+4 (bit 2 = 1), data bits [31:0], and capture into rdata[31:0]. On Done go to RESP.
- RESP (1 cycle):
  - resp_valid=1 and resp_err as recorded; resp_rdata holds the assembled word (0 for writes).
  - Go to IDLE; req_ready returns the next cycle.
  - No backpressure on the response.
- Done handling:
  - Done is sampled only in WAIT states.
  - A Done in the same cycle as the strobe (ISSUE state) or in IDLE/RESP is ignored.
  - Minimum transaction: 6 cycles from accept to resp_valid with a 1-cycle responder. The team's pipelined banks ack 1 cycle after the strobe, giving accept→resp_valid in 6 cycles.
- Stability: resp_rdata and resp_err hold their values until the next accept.
- Width rule: ADDR_WIDTH=3 gives a 1-bit VMEAddr. Wider configs increment only bit 2 between the words, with no carry.

Optional Feature:
- Macro: VME_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to each WAIT state and increments each cycle without Done.
  - When it reaches TIMEOUT_CYCLES with no Done: set err and go directly to RESP, skipping the low word if the high word timed out.
  - Uncaptured rdata halves read as 0.
  - A Done arriving on the same cycle as the limit is honoured (no error).
- Undefined: no counter; WAIT states wait indefinitely; resp_err is tied 0.

Test Plan:
- Write 0x1122334455667788 at addr 0, responder acks 1 cycle after each strobe -> VMEWrMem pulses with VMEAddr=0, data 0x11223344, then VMEAddr=1, data 0x55667788; resp_valid 6 cycles after accept, resp_err=0.
- Read addr 0, responder returns 0xDEADBEEF (addr 0) then 0x0BADF00D (addr 1) -> resp_rdata=0xDEADBEEF0BADF00D, exactly two VMERdMem pulses.
- req_valid held high continuously -> req_ready low during transaction; back-to-back transactions separated by exactly one IDLE cycle, no duplicated strobes.
- Spurious VMEWrDone during a read and a VMERdDone during IDLE -> ignored; read completes only on VMERdDone; no extra response.
- Rst asserted in WAIT_HI -> strobes/outputs 0 asynchronously, no resp_valid; after release a new read completes normally.
- With VME_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, responder silent on the high word -> resp_valid with resp_err=1, resp_rdata=0, no low-word strobe; Done on the 4th wait cycle -> no error.

Source files
------------

// File: rtl/vme_master_wide64.sv
// 64-bit host request initiator: splits each request into two 32-bit single-strobe VME accesses.
// Optional per-word Done timeout is enabled by defining VME_MASTER_TIMEOUT_EN.
module vme_master_wide64 #(
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    output logic [63:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-3:0] VMEAddr,
    output logic [31:0]           VMEWrData,
    input  logic [31:0]           VMERdData,
    output logic                  VMERdMem,
    output logic                  VMEWrMem,
    input  logic                  VMERdDone,
    input  logic                  VMEWrDone
);
    localparam int AW = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE, ISSUE_HI, WAIT_HI, ISSUE_LO, WAIT_LO, RESP
    } state_t;

    state_t        state, state_nxt;
    logic          write_q;
    logic [AW-1:0] base_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q;
    logic          err_q;
    logic          accept;
    logic          done;
    logic          timeout;
    logic          drive_bus;
    logic          lo_word;

    assign accept    = req_valid & req_ready;
    // Only the acknowledge matching the issued command counts.
    assign done      = write_q ? VMEWrDone : VMERdDone;
    assign drive_bus = (state == ISSUE_HI) || (state == WAIT_HI) ||
                       (state == ISSUE_LO) || (state == WAIT_LO);
    assign lo_word   = (state == ISSUE_LO) || (state == WAIT_LO);

    assign VMEAddr    = drive_bus ? (base_q | AW'(lo_word)) : '0;
    assign VMEWrData  = drive_bus ? (lo_word ? wdata_q[31:0] : wdata_q[63:32]) : '0;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef VME_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait = (state == WAIT_HI) || (state == WAIT_LO);
    // The limit cycle is the TIMEOUT_CYCLES-th wait cycle; a Done there still wins.
    assign timeout = in_wait && !done && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            wait_cnt <= '0;
        else if ((state == ISSUE_HI) || (state == ISSUE_LO))
            wait_cnt <= '0;
        else if (in_wait)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        VMERdMem   = 1'b0;
        VMEWrMem   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ISSUE_HI;
            end
            ISSUE_HI, ISSUE_LO: begin
                VMEWrMem  = write_q;
                VMERdMem  = !write_q;
                state_nxt = (state == ISSUE_HI) ? WAIT_HI : WAIT_LO;
            end
            WAIT_HI: begin
                if (done)         state_nxt = ISSUE_LO;
                else if (timeout) state_nxt = RESP;
            end
            WAIT_LO: begin
                if (done || timeout) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: captured command and data are cleared by reset too, so outputs read 0 after it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            write_q <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                base_q  <= AW'(req_addr >> 2) & ~AW'(1);
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if ((state == WAIT_HI) && done && !write_q)
                rdata_q[63:32] <= VMERdData;
            if ((state == WAIT_LO) && done && !write_q)
                rdata_q[31:0] <= VMERdData;
            if (timeout)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vme_master_wide64.sv
// Self-checking bench for vme_master_wide64 with a scoreboard of expected strobes and responses.
// Define VME_MASTER_TIMEOUT_EN to also exercise the timeout feature (TIMEOUT_CYCLES=4).
module tb_vme_master_wide64;
    localparam int ADDR_WIDTH = 6;
    localparam int AW         = ADDR_WIDTH - 2;
`ifdef VME_MASTER_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 4;
`else
    localparam int TIMEOUT_CYCLES = 255;
`endif

    logic                  Clk;
    logic                  Rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [63:0]           req_wdata;
    logic                  resp_valid;
    logic [63:0]           resp_rdata;
    logic                  resp_err;
    logic [AW-1:0]         VMEAddr;
    logic [31:0]           VMEWrData;
    logic [31:0]           VMERdData;
    logic                  VMERdMem;
    logic                  VMEWrMem;
    logic                  VMERdDone;
    logic                  VMEWrDone;

    vme_master_wide64 #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .VMEAddr   (VMEAddr),
        .VMEWrData (VMEWrData),
        .VMERdData (VMERdData),
        .VMERdMem  (VMERdMem),
        .VMEWrMem  (VMEWrMem),
        .VMERdDone (VMERdDone),
        .VMEWrDone (VMEWrDone)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } strobe_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    strobe_t     exp_strobes[$];
    resp_t       exp_resps[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_count = 0;
    int          last_resp_cyc = 0;
    logic [31:0] mem [16];

    // Responder controls: auto mode acks one cycle after each strobe; manual lines override.
    logic          auto_en;
    logic          arm_pending;
    logic          arm_we;
    logic [AW-1:0] arm_addr;
    logic          auto_rd_done;
    logic          auto_wr_done;
    logic [31:0]   auto_rdata;
    logic          man_rd_done;
    logic          man_wr_done;
    logic [31:0]   man_rdata;

    assign VMERdDone = auto_rd_done | man_rd_done;
    assign VMEWrDone = auto_wr_done | man_wr_done;
    assign VMERdData = man_rd_done ? man_rdata : auto_rdata;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Rst) begin
            arm_pending  <= 1'b0;
            arm_we       <= 1'b0;
            arm_addr     <= '0;
            auto_rd_done <= 1'b0;
            auto_wr_done <= 1'b0;
            auto_rdata   <= '0;
        end else begin
            auto_rd_done <= 1'b0;
            auto_wr_done <= 1'b0;
            if (arm_pending) begin
                arm_pending <= 1'b0;
                if (arm_we) begin
                    auto_wr_done <= 1'b1;
                end else begin
                    auto_rd_done <= 1'b1;
                    auto_rdata   <= mem[arm_addr];
                end
            end
            if (auto_en && (VMERdMem || VMEWrMem)) begin
                arm_pending <= 1'b1;
                arm_we      <= VMEWrMem;
                arm_addr    <= VMEAddr;
            end
        end
    end

    // Monitor: every strobe and response is popped from the scoreboard and compared.
    always @(negedge Clk) begin
        strobe_t s;
        resp_t   r;
        if (!Rst) begin
            if (VMERdMem && VMEWrMem) begin
                checks++; errors++;
                $display("FAIL both_strobes cyc=%0d rd=%b wr=%b required one-hot", cyc, VMERdMem, VMEWrMem);
            end
            if (VMERdMem || VMEWrMem) begin
                checks++;
                if (exp_strobes.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d wr=%b addr=%0d required none", cyc, VMEWrMem, VMEAddr);
                end else begin
                    s = exp_strobes.pop_front();
                    if (VMEWrMem !== s.we || VMEAddr !== s.addr || (s.we && VMEWrData !== s.data)) begin
                        errors++;
                        $display("FAIL strobe cyc=%0d got wr=%b addr=%0d data=%h required wr=%b addr=%0d data=%h",
                                 cyc, VMEWrMem, VMEAddr, VMEWrData, s.we, s.addr, s.data);
                    end
                end
            end
            if (resp_valid) begin
                checks++;
                resp_count++;
                last_resp_cyc = cyc;
                if (exp_resps.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp cyc=%0d rdata=%h err=%b required none", cyc, resp_rdata, resp_err);
                end else begin
                    r = exp_resps.pop_front();
                    if (resp_rdata !== r.rdata || resp_err !== r.err) begin
                        errors++;
                        $display("FAIL resp cyc=%0d got rdata=%h err=%b required rdata=%h err=%b",
                                 cyc, resp_rdata, resp_err, r.rdata, r.err);
                    end
                end
            end
        end
    end

    task automatic push_txn(input logic we, input logic [ADDR_WIDTH-1:0] addr, input logic [63:0] wdata,
                            input logic [63:0] exp_rdata, input logic exp_err,
                            input bit expect_lo, input bit expect_resp);
        strobe_t s;
        resp_t   r;
        s.we   = we;
        s.addr = {addr[5:3], 1'b0};
        s.data = wdata[63:32];
        exp_strobes.push_back(s);
        if (expect_lo) begin
            s.addr = {addr[5:3], 1'b1};
            s.data = wdata[31:0];
            exp_strobes.push_back(s);
        end
        if (expect_resp) begin
            r.rdata = exp_rdata;
            r.err   = exp_err;
            exp_resps.push_back(r);
        end
    endtask

    // Returns at the falling edge inside the ISSUE_HI cycle.
    task automatic issue(input logic we, input logic [ADDR_WIDTH-1:0] addr, input logic [63:0] wdata,
                         output int acc_cyc);
        int g = 0;
        @(negedge Clk);
        req_valid = 1'b1;
        req_write = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && g < 50) begin
            @(negedge Clk);
            g++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout cyc=%0d req_ready=%b required 1", cyc, req_ready);
        end
        acc_cyc = cyc;
        @(negedge Clk);
        req_valid = 1'b0;
        req_write = ~we;
        req_addr  = 6'h3F;
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_resp();
        int target = resp_count + 1;
        int g = 0;
        while (resp_count < target && g < 100) begin
            @(negedge Clk);
            #1;
            g++;
        end
        if (resp_count < target) begin
            checks++; errors++;
            $display("FAIL resp_timeout cyc=%0d responses=%0d required %0d", cyc, resp_count, target);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        checks++;
        if ({req_ready, resp_valid, VMERdMem, VMEWrMem, resp_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got ready/valid/rd/wr/err=%b required 10000",
                     {req_ready, resp_valid, VMERdMem, VMEWrMem, resp_err});
        end
        checks++;
        if (VMEAddr !== '0 || VMEWrData !== '0 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%0d wdata=%h rdata=%h required 0", VMEAddr, VMEWrData, resp_rdata);
        end
        Rst = 1'b0;
    endtask

    task automatic test_write();
        int acc;
        auto_en = 1'b1;
        push_txn(1'b1, 6'h00, 64'h1122334455667788, 64'h0, 1'b0, 1'b1, 1'b1);
        issue(1'b1, 6'h00, 64'h1122334455667788, acc);
        wait_resp();
        checks++;
        if (last_resp_cyc - acc !== 5) begin
            errors++;
            $display("FAIL write_latency got %0d edges required 5 (6th cycle)", last_resp_cyc - acc);
        end
        checks++;
        if (exp_strobes.size() !== 0) begin
            errors++;
            $display("FAIL write_strobes pending=%0d required 0", exp_strobes.size());
        end
    endtask

    task automatic test_read();
        int acc;
        auto_en = 1'b1;
        push_txn(1'b0, 6'h03, 64'h0, 64'hDEADBEEF0BADF00D, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 6'h03, 64'h5555AAAA5555AAAA, acc);
        wait_resp();
        checks++;
        if (last_resp_cyc - acc !== 5) begin
            errors++;
            $display("FAIL read_latency got %0d edges required 5", last_resp_cyc - acc);
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (resp_rdata !== 64'hDEADBEEF0BADF00D || resp_err !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_hold got rdata=%h err=%b valid=%b required DEADBEEF0BADF00D 0 0",
                     resp_rdata, resp_err, resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic                  we_a [3] = '{1'b1, 1'b0, 1'b1};
        logic [ADDR_WIDTH-1:0] ad_a [3] = '{6'h2D, 6'h28, 6'h17};
        logic [63:0]           wd_a [3] = '{64'hA5A50001_5A5A0002, 64'h0, 64'hCAFEF00D_12345678};
        logic [63:0]           rd_a [3] = '{64'h0, 64'hCAFEBABE_FEEDFACE, 64'h0};
        int acc [3];
        int n = 0;
        int g = 0;
        int start = resp_count;
        auto_en = 1'b1;
        @(negedge Clk);
        push_txn(we_a[0], ad_a[0], wd_a[0], rd_a[0], 1'b0, 1'b1, 1'b1);
        req_write = we_a[0]; req_addr = ad_a[0]; req_wdata = wd_a[0];
        req_valid = 1'b1;
        while (n < 3 && g < 100) begin
            if (req_ready) begin
                acc[n] = cyc;
                n++;
                @(negedge Clk);
                if (n < 3) begin
                    push_txn(we_a[n], ad_a[n], wd_a[n], rd_a[n], 1'b0, 1'b1, 1'b1);
                    req_write = we_a[n]; req_addr = ad_a[n]; req_wdata = wd_a[n];
                end else begin
                    req_valid = 1'b0;
                end
            end else begin
                @(negedge Clk);
            end
            g++;
        end
        req_valid = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL b2b_accepts got %0d required 3", n);
        end else begin
            checks++;
            if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
                errors++;
                $display("FAIL b2b_spacing got %0d,%0d required 6,6", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        g = 0;
        while (resp_count < start + 3 && g < 100) begin
            @(negedge Clk);
            #1;
            g++;
        end
        checks++;
        if (resp_count !== start + 3 || exp_strobes.size() !== 0) begin
            errors++;
            $display("FAIL b2b_done responses=%0d pending_strobes=%0d required %0d,0",
                     resp_count - start, exp_strobes.size(), 3);
        end
    endtask

    task automatic test_spurious();
        int acc;
        int start;
        auto_en = 1'b0;
        @(negedge Clk);
        man_rd_done = 1'b1;
        man_rdata   = 32'hFFFFFFFF;
        @(negedge Clk);
        man_rd_done = 1'b0;
        start = resp_count;
        push_txn(1'b0, 6'h08, 64'h0, 64'h13579BDF_2468ACE0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 6'h08, 64'h0, acc);
        // Done during the strobe cycle must not count.
        man_rd_done = 1'b1;
        man_rdata   = 32'h0BAD0BAD;
        @(negedge Clk);
        man_rd_done = 1'b0;
        man_wr_done = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if (VMEAddr !== 4'd2 || VMERdMem !== 1'b0 || resp_count !== start) begin
            errors++;
            $display("FAIL spurious_wait got addr=%0d rd=%b responses=%0d required 2 0 %0d",
                     VMEAddr, VMERdMem, resp_count, start);
        end
        man_wr_done = 1'b0;
        man_rd_done = 1'b1;
        man_rdata   = 32'h13579BDF;
        auto_en     = 1'b1;
        @(negedge Clk);
        man_rd_done = 1'b0;
        wait_resp();
        repeat (5) @(negedge Clk);
        #1;
        checks++;
        if (resp_count !== start + 1) begin
            errors++;
            $display("FAIL spurious_count got %0d responses required 1", resp_count - start);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int start;
        auto_en = 1'b0;
        push_txn(1'b0, 6'h10, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 6'h10, 64'h0, acc);
        @(negedge Clk);
        checks++;
        if (VMEAddr !== 4'd4 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre got addr=%0d ready=%b required 4 0", VMEAddr, req_ready);
        end
        start = resp_count;
        #2 Rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, VMERdMem, VMEWrMem} !== 4'b1000 || VMEAddr !== '0 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL midrst_async got ready/valid/rd/wr=%b addr=%0d rdata=%h required 1000 0 0",
                     {req_ready, resp_valid, VMERdMem, VMEWrMem}, VMEAddr, resp_rdata);
        end
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        #1;
        checks++;
        if (resp_count !== start) begin
            errors++;
            $display("FAIL midrst_noresp got %0d responses required 0", resp_count - start);
        end
        auto_en = 1'b1;
        push_txn(1'b0, 6'h00, 64'h0, 64'hDEADBEEF0BADF00D, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 6'h00, 64'h0, acc);
        wait_resp();
    endtask

`ifdef VME_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int acc;
        auto_en = 1'b0;
        push_txn(1'b0, 6'h08, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 6'h08, 64'h0, acc);
        wait_resp();
        checks++;
        if (last_resp_cyc - acc !== 6) begin
            errors++;
            $display("FAIL timeout_latency got %0d edges required 6", last_resp_cyc - acc);
        end
        push_txn(1'b0, 6'h08, 64'h0, 64'h13579BDF_2468ACE0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 6'h08, 64'h0, acc);
        repeat (4) @(negedge Clk);
        man_rd_done = 1'b1;
        man_rdata   = 32'h13579BDF;
        auto_en     = 1'b1;
        @(negedge Clk);
        man_rd_done = 1'b0;
        wait_resp();
    endtask
`endif

    initial begin
        Rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        auto_en     = 1'b0;
        man_rd_done = 1'b0;
        man_wr_done = 1'b0;
        man_rdata   = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'hDEADBEEF;
        mem[1]  = 32'h0BADF00D;
        mem[2]  = 32'h13579BDF;
        mem[3]  = 32'h2468ACE0;
        mem[10] = 32'hCAFEBABE;
        mem[11] = 32'hFEEDFACE;

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
`ifdef VME_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (5) @(negedge Clk);
        checks++;
        if (exp_strobes.size() !== 0 || exp_resps.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain strobes=%0d resps=%0d required 0,0",
                     exp_strobes.size(), exp_resps.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
